mips_data_sram_req: RTL and testbench

//  Issues one data-SRAM access at a time for a load/store from the execute stage: word-aligns the address,

---
 rtl/mips_data_sram_req_if.sv | 40 ++++
 rtl/mips_data_sram_req.sv | 234 +++++++++++++++++++++++
 tb/tb_mips_data_sram_req.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_data_sram_req_if.sv
// Data-SRAM sram-like bus between the load/store request block and the SRAM bridge.
// Latency: none; this is wiring only.
// Backpressure: the bridge stalls the request by withholding data_addr_ok and the completion by withholding data_data_ok.
interface mips_data_sram_req_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    // Request side: the block that issues the access.
    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wstrb,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    // Bridge side: the SRAM bridge that serves the access.
    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wstrb,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/mips_data_sram_req.sv
// Issues one data-SRAM load/store at a time: aligns the address, builds strobes/lane data, and checks alignment.
// Latency: accept c0, data_req c1, response pulse one cycle after data_data_ok (c3 minimum); address errors respond at c1.
// Backpressure: req_ready is low from acceptance until the access finishes; flush kills the op and suppresses its response.
module mips_data_sram_req #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [11:0]                req_op,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    mips_data_sram_req_if.master       bus,
    output logic                       rsp_valid,
    output logic                       rsp_wr,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_adel,
    output logic                       rsp_ades,
    output logic [31:0]                rsp_badvaddr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // One-hot op decode
    logic op_lw, op_lb, op_lbu, op_lh, op_lhu, op_lwl, op_lwr;
    logic op_sw, op_sb, op_sh, op_swl, op_swr;

    assign op_lw  = req_op[0];
    assign op_lb  = req_op[1];
    assign op_lbu = req_op[2];
    assign op_lh  = req_op[3];
    assign op_lhu = req_op[4];
    assign op_lwl = req_op[5];
    assign op_lwr = req_op[6];
    assign op_sw  = req_op[7];
    assign op_sb  = req_op[8];
    assign op_sh  = req_op[9];
    assign op_swl = req_op[10];
    assign op_swr = req_op[11];

    logic [1:0] lane;
    logic       is_store;
    logic       is_null;
    logic       mis_half;
    logic       mis_word;
    logic       misaligned;
    logic       xfer;
    logic       issue;

    assign lane       = req_addr[1:0];
    assign is_store   = |req_op[11:7];
    assign is_null    = (req_op == 12'd0);
    assign mis_half   = (op_lh | op_lhu | op_sh) & lane[0];
    assign mis_word   = (op_lw | op_sw) & (lane != 2'd0);
    assign misaligned = ALIGN_CHECK & (mis_half | mis_word);

    // A transfer that is an address error or a null op completes immediately without touching the bus.
    assign req_ready  = (state == IDLE);
    assign xfer       = req_valid & req_ready & ~flush;
    assign issue      = xfer & ~misaligned & ~is_null;

    // Bus fields computed from the incoming request
    logic        nxt_wr;
    logic [1:0]  nxt_size;
    logic [31:0] nxt_addr;
    logic [3:0]  nxt_wstrb;
    logic [31:0] nxt_wdata;

    // Build address, size, byte strobes and lane-aligned store data for the offered op.
    always_comb begin
        nxt_wr    = is_store;
        nxt_addr  = req_addr;
        nxt_size  = 2'd2;
        nxt_wstrb = 4'b0000;
        nxt_wdata = 32'd0;

        if (op_lwl | op_lwr | op_swl | op_swr) begin
            nxt_addr = {req_addr[31:2], 2'b00};
        end

        if (op_lb | op_lbu | op_sb) begin
            nxt_size = 2'd0;
        end else if (op_lh | op_lhu | op_sh) begin
            nxt_size = 2'd1;
        end

        if (op_sb) begin
            nxt_wstrb = 4'b0001 << lane;
            nxt_wdata = {4{req_wdata[7:0]}};
        end else if (op_sh) begin
            nxt_wstrb = lane[1] ? 4'b1100 : 4'b0011;
            nxt_wdata = {2{req_wdata[15:0]}};
        end else if (op_sw) begin
            nxt_wstrb = 4'b1111;
            nxt_wdata = req_wdata;
        end else if (op_swl) begin
            // Left part: the high bytes of rt go to the low lanes up to the addressed byte.
            case (lane)
                2'd0: begin nxt_wstrb = 4'b0001; nxt_wdata = {24'd0, req_wdata[31:24]}; end
                2'd1: begin nxt_wstrb = 4'b0011; nxt_wdata = {16'd0, req_wdata[31:16]}; end
                2'd2: begin nxt_wstrb = 4'b0111; nxt_wdata = {8'd0,  req_wdata[31:8]};  end
                default: begin nxt_wstrb = 4'b1111; nxt_wdata = req_wdata; end
            endcase
        end else if (op_swr) begin
            // Right part: the low bytes of rt go to the addressed byte and above.
            case (lane)
                2'd0: begin nxt_wstrb = 4'b1111; nxt_wdata = req_wdata; end
                2'd1: begin nxt_wstrb = 4'b1110; nxt_wdata = {req_wdata[23:0], 8'd0};  end
                2'd2: begin nxt_wstrb = 4'b1100; nxt_wdata = {req_wdata[15:0], 16'd0}; end
                default: begin nxt_wstrb = 4'b1000; nxt_wdata = {req_wdata[7:0], 24'd0}; end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    logic done_ok;

    // Next-state logic; done_ok marks a load/store finishing without a kill.
    always_comb begin
        state_nxt = state;
        done_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    // Once the bridge has taken the request its data_ok must still be absorbed.
                    state_nxt = bus.data_addr_ok ? DROP : IDLE;
                end else if (bus.data_addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.data_data_ok) begin
                    // A flush coinciding with data_ok still kills the response, but the bus is done.
                    state_nxt = IDLE;
                    done_ok   = ~flush;
                end else if (flush) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (bus.data_data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    logic        cur_wr;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr;
    logic [3:0]  cur_wstrb;
    logic [31:0] cur_wdata;

    // Capture bus fields on issue so they stay stable while data_req is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_wr    <= 1'b0;
            cur_size  <= 2'd0;
            cur_addr  <= 32'd0;
            cur_wstrb <= 4'd0;
            cur_wdata <= 32'd0;
        end else if (issue) begin
            cur_wr    <= nxt_wr;
            cur_size  <= nxt_size;
            cur_addr  <= nxt_addr;
            cur_wstrb <= nxt_wstrb;
            cur_wdata <= nxt_wdata;
        end
    end

    assign bus.data_req   = (state == REQ);
    assign bus.data_wr    = cur_wr;
    assign bus.data_size  = cur_size;
    assign bus.data_addr  = cur_addr;
    assign bus.data_wstrb = cur_wstrb;
    assign bus.data_wdata = cur_wdata;

    // One-cycle response pulse: either an immediate address-error/null completion or a finished bus access.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid    <= 1'b0;
            rsp_wr       <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_adel     <= 1'b0;
            rsp_ades     <= 1'b0;
            rsp_badvaddr <= 32'd0;
        end else begin
            rsp_valid    <= 1'b0;
            rsp_wr       <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_adel     <= 1'b0;
            rsp_ades     <= 1'b0;
            rsp_badvaddr <= 32'd0;
            if (xfer && !issue) begin
                rsp_valid    <= 1'b1;
                rsp_wr       <= is_store;
                rsp_adel     <= misaligned & ~is_store;
                rsp_ades     <= misaligned & is_store;
                rsp_badvaddr <= misaligned ? req_addr : 32'd0;
            end else if (done_ok) begin
                rsp_valid <= 1'b1;
                rsp_wr    <= cur_wr;
                rsp_rdata <= cur_wr ? 32'd0 : bus.data_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mips_data_sram_req.sv
// Directed bench for mips_data_sram_req with a per-op bridge model and hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// Bridge timing per op is set by addr_ok/data_ok delays passed to run_op.
module tb_mips_data_sram_req;

    localparam logic [11:0] OP_LW  = 12'h001;
    localparam logic [11:0] OP_LB  = 12'h002;
    localparam logic [11:0] OP_LH  = 12'h008;
    localparam logic [11:0] OP_LWL = 12'h020;
    localparam logic [11:0] OP_SW  = 12'h080;
    localparam logic [11:0] OP_SB  = 12'h100;
    localparam logic [11:0] OP_SH  = 12'h200;
    localparam logic [11:0] OP_SWL = 12'h400;
    localparam logic [11:0] OP_SWR = 12'h800;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_wr;
    logic [31:0] rsp_rdata;
    logic        rsp_adel;
    logic        rsp_ades;
    logic [31:0] rsp_badvaddr;

    mips_data_sram_req_if bus();

    mips_data_sram_req #(.ALIGN_CHECK(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .bus          (bus),
        .rsp_valid    (rsp_valid),
        .rsp_wr       (rsp_wr),
        .rsp_rdata    (rsp_rdata),
        .rsp_adel     (rsp_adel),
        .rsp_ades     (rsp_ades),
        .rsp_badvaddr (rsp_badvaddr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Values captured by run_op
    int          n_req;
    int          n_rsp;
    int          rsp_cyc;
    logic        cap_wr;
    logic [1:0]  cap_size;
    logic [31:0] cap_addr;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_wdata;
    logic        cap_rsp_wr;
    logic [31:0] cap_rdata;
    logic        cap_adel;
    logic        cap_ades;
    logic [31:0] cap_bad;

    // Offer one op, then serve it for a fixed window: addr_ok on the (aok_dly+1)th data_req cycle,
    // data_ok dok_dly cycles after addr_ok. Cycle index 0 is the cycle after acceptance.
    task automatic run_op(input logic [11:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int aok_dly, input int dok_dly, input logic [31:0] rd);
        int aok_cyc;
        aok_cyc = -1;
        n_req = 0; n_rsp = 0; rsp_cyc = -1;
        cap_wr = 1'b0; cap_size = 2'd0; cap_addr = 32'd0; cap_wstrb = 4'd0; cap_wdata = 32'd0;
        cap_rsp_wr = 1'b0; cap_rdata = 32'd0; cap_adel = 1'b0; cap_ades = 1'b0; cap_bad = 32'd0;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_op = 12'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int c = 0; c < 16; c++) begin
            if (rsp_valid) begin
                if (n_rsp == 0) begin
                    rsp_cyc    = c;
                    cap_rsp_wr = rsp_wr;
                    cap_rdata  = rsp_rdata;
                    cap_adel   = rsp_adel;
                    cap_ades   = rsp_ades;
                    cap_bad    = rsp_badvaddr;
                end
                n_rsp++;
            end
            if (bus.data_req) begin
                if (n_req == 0) begin
                    cap_wr    = bus.data_wr;
                    cap_size  = bus.data_size;
                    cap_addr  = bus.data_addr;
                    cap_wstrb = bus.data_wstrb;
                    cap_wdata = bus.data_wdata;
                end
                n_req++;
            end
            bus.data_addr_ok = bus.data_req && (n_req == aok_dly + 1);
            if (bus.data_addr_ok) aok_cyc = c;
            bus.data_data_ok = (aok_cyc >= 0) && (c == aok_cyc + dok_dly);
            bus.data_rdata   = bus.data_data_ok ? rd : 32'h0BAD_F00D;
            @(negedge clk);
        end
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 12'd0; req_addr = 32'd0; req_wdata = 32'd0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_data_req", 32'(bus.data_req), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_wstrb", 32'(bus.data_wstrb), 32'd0);
        check("rst_addr", bus.data_addr, 32'd0);
        check("rst_badvaddr", rsp_badvaddr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // SB to byte 3 at minimum latency
        run_op(OP_SB, 32'h0000_1003, 32'h1122_3344, 0, 1, 32'h5555_5555);
        check("sb_nreq", 32'(n_req), 32'd1);
        check("sb_wr", 32'(cap_wr), 32'd1);
        check("sb_size", 32'(cap_size), 32'd0);
        check("sb_addr", cap_addr, 32'h0000_1003);
        check("sb_wstrb", 32'(cap_wstrb), 32'h8);
        check("sb_wdata", cap_wdata, 32'h4444_4444);
        check("sb_nrsp", 32'(n_rsp), 32'd1);
        check("sb_rsp_cyc", 32'(rsp_cyc), 32'd2);
        check("sb_rsp_wr", 32'(cap_rsp_wr), 32'd1);
        check("sb_rsp_rdata", cap_rdata, 32'd0);

        // LW with addr_ok stalled 3 cycles and data_ok 2 cycles after it
        run_op(OP_LW, 32'h0000_2000, 32'hFFFF_FFFF, 3, 2, 32'hDEAD_BEEF);
        check("lw_nreq", 32'(n_req), 32'd4);
        check("lw_size", 32'(cap_size), 32'd2);
        check("lw_wr", 32'(cap_wr), 32'd0);
        check("lw_wstrb", 32'(cap_wstrb), 32'd0);
        check("lw_wdata", cap_wdata, 32'd0);
        check("lw_nrsp", 32'(n_rsp), 32'd1);
        check("lw_rsp_cyc", 32'(rsp_cyc), 32'd6);
        check("lw_rdata", cap_rdata, 32'hDEAD_BEEF);
        check("lw_rsp_wr", 32'(cap_rsp_wr), 32'd0);

        // SWL / SWR partial-word stores
        run_op(OP_SWL, 32'h0000_AB01, 32'hAABB_CCDD, 0, 1, 32'd0);
        check("swl_addr", cap_addr, 32'h0000_AB00);
        check("swl_wstrb", 32'(cap_wstrb), 32'h3);
        check("swl_wdata", cap_wdata, 32'h0000_AABB);
        check("swl_size", 32'(cap_size), 32'd2);
        run_op(OP_SWR, 32'h0000_AB02, 32'hAABB_CCDD, 1, 1, 32'd0);
        check("swr_addr", cap_addr, 32'h0000_AB00);
        check("swr_wstrb", 32'(cap_wstrb), 32'hC);
        check("swr_wdata", cap_wdata, 32'hCCDD_0000);
        check("swr_nrsp", 32'(n_rsp), 32'd1);

        // SH upper half, LWL and LB address/size rules
        run_op(OP_SH, 32'h0000_1002, 32'h1234_5678, 0, 1, 32'd0);
        check("sh_size", 32'(cap_size), 32'd1);
        check("sh_wstrb", 32'(cap_wstrb), 32'hC);
        check("sh_wdata", cap_wdata, 32'h5678_5678);
        run_op(OP_LWL, 32'h0000_5003, 32'd0, 0, 1, 32'h0102_0304);
        check("lwl_addr", cap_addr, 32'h0000_5000);
        check("lwl_size", 32'(cap_size), 32'd2);
        check("lwl_rdata", cap_rdata, 32'h0102_0304);
        run_op(OP_LB, 32'h0000_5003, 32'd0, 0, 1, 32'hA0B0_C0D0);
        check("lb_addr", cap_addr, 32'h0000_5003);
        check("lb_size", 32'(cap_size), 32'd0);

        // Misaligned LH -> AdEL without bus access
        run_op(OP_LH, 32'h0000_1001, 32'd0, 0, 1, 32'd0);
        check("lh_nreq", 32'(n_req), 32'd0);
        check("lh_nrsp", 32'(n_rsp), 32'd1);
        check("lh_rsp_cyc", 32'(rsp_cyc), 32'd0);
        check("lh_adel", 32'(cap_adel), 32'd1);
        check("lh_ades", 32'(cap_ades), 32'd0);
        check("lh_badvaddr", cap_bad, 32'h0000_1001);

        // Misaligned SW -> AdES
        run_op(OP_SW, 32'h0000_4002, 32'h1111_2222, 0, 1, 32'd0);
        check("sw_nreq", 32'(n_req), 32'd0);
        check("sw_ades", 32'(cap_ades), 32'd1);
        check("sw_adel", 32'(cap_adel), 32'd0);
        check("sw_badvaddr", cap_bad, 32'h0000_4002);
        check("sw_rsp_wr", 32'(cap_rsp_wr), 32'd1);

        // Flush in WAIT: data_ok two cycles later is absorbed, no response
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_3000;
        @(negedge clk);
        req_valid = 1'b0; req_op = 12'd0; req_addr = 32'd0;
        check("fw_data_req", 32'(bus.data_req), 32'd1);
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fw_ready_drop", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("fw_ready_drop2", 32'(req_ready), 32'd0);
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h7777_7777;
        @(negedge clk);
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
        check("fw_ready_after", 32'(req_ready), 32'd1);
        check("fw_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("fw_no_rsp2", 32'(rsp_valid), 32'd0);
        run_op(OP_LW, 32'h0000_3004, 32'd0, 0, 1, 32'hCAFE_0001);
        check("fw_next_nrsp", 32'(n_rsp), 32'd1);
        check("fw_next_rdata", cap_rdata, 32'hCAFE_0001);

        // Flush in REQ before addr_ok returns straight to IDLE
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_3100;
        @(negedge clk);
        req_valid = 1'b0; req_op = 12'd0; req_addr = 32'd0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fr_ready", 32'(req_ready), 32'd1);
        check("fr_data_req", 32'(bus.data_req), 32'd0);
        @(negedge clk);
        check("fr_no_rsp", 32'(rsp_valid), 32'd0);

        // Flush in IDLE blocks acceptance
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_3200; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_op = 12'd0; req_addr = 32'd0; flush = 1'b0;
        check("fi_data_req", 32'(bus.data_req), 32'd0);
        check("fi_ready", 32'(req_ready), 32'd1);
        check("fi_no_rsp", 32'(rsp_valid), 32'd0);

        // Reset while in REQ abandons the access
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h0000_6000; req_wdata = 32'h1357_9BDF;
        @(negedge clk);
        req_valid = 1'b0; req_op = 12'd0; req_addr = 32'd0; req_wdata = 32'd0;
        check("rr_data_req", 32'(bus.data_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_data_req_off", 32'(bus.data_req), 32'd0);
        check("rr_ready", 32'(req_ready), 32'd1);
        check("rr_wstrb", 32'(bus.data_wstrb), 32'd0);
        check("rr_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("rr_no_rsp2", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
